// File: rtl/gnr_sweep_sched_if.sv
// Port bundle for gnr_sweep_sched: host controls, node-array controls and
// the result record port. The master modport is the scheduler side.
//
// Result handshake: a record transfers on a rising clk edge where
// result_valid and result_ready are both high; while result_valid is high
// and result_ready is low, result_init/result_steps/result_period hold
// their values and the scheduler does not advance.
interface gnr_sweep_sched_if #(
    parameter int NUM_NODES = 8,
    parameter int ITER_W    = 16
);
    logic                 start;
    logic [NUM_NODES-1:0] init_base;
    logic [ITER_W-1:0]    num_init;
    logic [ITER_W-1:0]    max_iter;
    logic [NUM_NODES-1:0] nodes_state;
    logic                 reset_nos;
    logic [NUM_NODES-1:0] init_state;
    logic                 start_s0;
    logic                 start_s1;
    logic                 result_valid;
    logic                 result_ready;
    logic [NUM_NODES-1:0] result_init;
    logic [ITER_W-1:0]    result_steps;
    logic [1:0]           result_period;
    logic                 busy;
    logic                 done;
    logic [2:0]           state_dbg;

    modport master (
        input  start, init_base, num_init, max_iter, nodes_state, result_ready,
        output reset_nos, init_state, start_s0, start_s1, result_valid,
               result_init, result_steps, result_period, busy, done, state_dbg
    );

    modport slave (
        output start, init_base, num_init, max_iter, nodes_state, result_ready,
        input  reset_nos, init_state, start_s0, start_s1, result_valid,
               result_init, result_steps, result_period, busy, done, state_dbg
    );
endinterface

// File: rtl/gnr_sweep_sched.sv
// Gene-regulatory-network sweep sequencer. Loads each initial state of a
// sweep into the node array, iterates it (PH0/PH1 strobes) until a fixed
// point or the iteration limit, and reports one record per initial state.
// Optional feature macro: GNR_SWEEP_PERIOD2_EN adds period-2 cycle detection.
module gnr_sweep_sched #(
    parameter int NUM_NODES = 8,
    parameter int ITER_W    = 16
) (
    input  logic clk,
    input  logic rst,
    gnr_sweep_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PH0  = 3'd2,
        PH1  = 3'd3,
        CHK  = 3'd4,
        RES  = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t               state;
    logic [NUM_NODES-1:0] base_q;
    logic [ITER_W-1:0]    num_q;
    logic [ITER_W-1:0]    max_q;
    logic [ITER_W-1:0]    idx;
    logic [ITER_W-1:0]    steps;
    logic [NUM_NODES-1:0] prev;
`ifdef GNR_SWEEP_PERIOD2_EN
    logic [NUM_NODES-1:0] prev2;
`endif

    logic [ITER_W-1:0]    steps_n;
    logic [ITER_W-1:0]    eff_max;
    logic [ITER_W-1:0]    idx_inc;
    logic [NUM_NODES-1:0] next_init;

    assign bus.state_dbg = state;

    // Helpers: saturating step count, limit with 0 read as 1, next sweep index.
    always_comb begin
        steps_n   = (steps == '1) ? steps : steps + ITER_W'(1);
        eff_max   = (max_q == '0) ? ITER_W'(1) : max_q;
        idx_inc   = idx + ITER_W'(1);
        next_init = base_q + NUM_NODES'(idx_inc);
    end

    // Sequencer FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            base_q            <= '0;
            num_q             <= '0;
            max_q             <= '0;
            idx               <= '0;
            steps             <= '0;
            prev              <= '0;
`ifdef GNR_SWEEP_PERIOD2_EN
            prev2             <= '0;
`endif
            bus.reset_nos     <= 1'b0;
            bus.init_state    <= '0;
            bus.start_s0      <= 1'b0;
            bus.start_s1      <= 1'b0;
            bus.result_valid  <= 1'b0;
            bus.result_init   <= '0;
            bus.result_steps  <= '0;
            bus.result_period <= 2'd0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            bus.reset_nos <= 1'b0;
            bus.start_s0  <= 1'b0;
            bus.start_s1  <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.init_base;
                        num_q    <= bus.num_init;
                        max_q    <= bus.max_iter;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        if (bus.num_init == '0) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            bus.reset_nos  <= 1'b1;
                            bus.init_state <= bus.init_base;
                        end
                    end
                end
                LOAD: begin
                    prev            <= bus.init_state;
                    steps           <= '0;
                    bus.result_init <= bus.init_state;
                    bus.start_s0    <= 1'b1;
                    state           <= PH0;
                end
                PH0: begin
                    bus.start_s1 <= 1'b1;
                    state        <= PH1;
                end
                PH1: begin
                    state <= CHK;
                end
                CHK: begin
                    steps <= steps_n;
                    if (bus.nodes_state == prev) begin
                        bus.result_period <= 2'd1;
                        bus.result_steps  <= steps_n;
                        bus.result_valid  <= 1'b1;
                        state             <= RES;
`ifdef GNR_SWEEP_PERIOD2_EN
                    end else if (steps_n >= ITER_W'(2) && bus.nodes_state == prev2) begin
                        bus.result_period <= 2'd2;
                        bus.result_steps  <= steps_n;
                        bus.result_valid  <= 1'b1;
                        state             <= RES;
`endif
                    end else if (steps_n >= eff_max) begin
                        bus.result_period <= 2'd0;
                        bus.result_steps  <= steps_n;
                        bus.result_valid  <= 1'b1;
                        state             <= RES;
                    end else begin
`ifdef GNR_SWEEP_PERIOD2_EN
                        prev2 <= prev;
`endif
                        prev         <= bus.nodes_state;
                        bus.start_s0 <= 1'b1;
                        state        <= PH0;
                    end
                end
                RES: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        idx              <= idx_inc;
                        if (idx_inc == num_q) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            bus.reset_nos  <= 1'b1;
                            bus.init_state <= next_init;
                        end
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gnr_sweep_sched.sv
// Bench for gnr_sweep_sched: node-array stub, directed sweeps, and a
// scoreboard of expected result records checked by a negedge monitor.
module tb_gnr_sweep_sched;
    localparam int N = 8;
    localparam int W = 16;
    localparam int RW = N + W + 2;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_INC  = 2'd1;
    localparam logic [1:0] MODE_ALT  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gnr_sweep_sched_if #(.NUM_NODES(N), .ITER_W(W)) bus();
    gnr_sweep_sched #(.NUM_NODES(N), .ITER_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- node array stub ----------------
    logic [1:0]   stub_mode;
    logic [N-1:0] node_s0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                node_s0 <= '0;
        else if (bus.reset_nos) node_s0 <= bus.init_state;
        else if (bus.start_s0) begin
            case (stub_mode)
                MODE_INC: node_s0 <= node_s0 + 8'd1;
                MODE_ALT: node_s0 <= ~node_s0;
                default:  node_s0 <= node_s0;
            endcase
        end
    end
    assign bus.nodes_state = node_s0;

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int s0_cnt   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [N-1:0] init, input logic [W-1:0] steps,
                                     input logic [1:0] period);
        exp_q.push_back({init, steps, period});
    endfunction

    // Monitor: counts PH0 strobes per record and checks each transferred record.
    always @(negedge clk) begin
        logic [RW-1:0] e;
        if (!rst) begin
            if (bus.reset_nos) s0_cnt = 0;
            if (bus.start_s0)  s0_cnt = s0_cnt + 1;
            if (bus.done)      done_cnt = done_cnt + 1;
            if (bus.result_valid && bus.result_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_record: got init %0h with no record expected",
                             bus.result_init);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_init",   32'(bus.result_init),   32'(e[RW-1 -: N]));
                    check("rec_steps",  32'(bus.result_steps),  32'(e[W+1 -: W]));
                    check("rec_period", 32'(bus.result_period), 32'(e[1:0]));
                    check("rec_ph0_pulses", 32'(s0_cnt), 32'(e[W+1 -: W]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [N-1:0] base, input logic [W-1:0] num,
                               input logic [W-1:0] max);
        bus.start     = 1'b1;
        bus.init_base = base;
        bus.num_init  = num;
        bus.max_iter  = max;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (k == 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still %0b after 2000 cycles, expected 0", name, bus.busy);
        end
        tick();
    endtask

    task automatic run_sweep(input string name, input logic [N-1:0] base,
                             input logic [W-1:0] num, input logic [W-1:0] max);
        int d0;
        d0 = done_cnt;
        start_sweep(base, num, max);
        wait_idle(name);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_records_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_reset_nos"}, 32'(bus.reset_nos), 32'd0);
        check({name, "_init_state"}, 32'(bus.init_state), 32'd0);
        check({name, "_strobes"}, 32'({bus.start_s0, bus.start_s1}), 32'd0);
        check({name, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({name, "_result_init"}, 32'(bus.result_init), 32'd0);
        check({name, "_result_steps"}, 32'(bus.result_steps), 32'd0);
        check({name, "_result_period"}, 32'(bus.result_period), 32'd0);
        check({name, "_busy_done"}, 32'({bus.busy, bus.done}), 32'd0);
        check({name, "_state"}, 32'(bus.state_dbg), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int k;
        rst              = 1'b1;
        stub_mode        = MODE_HOLD;
        bus.start        = 1'b0;
        bus.init_base    = '0;
        bus.num_init     = '0;
        bus.max_iter     = '0;
        bus.result_ready = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Fixed point with first-record latency check.
        stub_mode = MODE_HOLD;
        push_exp(8'h3C, 16'd1, 2'd1);
        d0 = done_cnt;
        start_sweep(8'h3C, 16'd1, 16'd10);
        check("load_reset_nos", 32'(bus.reset_nos), 32'd1);
        check("load_init_state", 32'(bus.init_state), 32'h3C);
        tick();
        tick();
        tick();
        check("latency_edge4_valid", 32'(bus.result_valid), 32'd0);
        tick();
        check("latency_edge5_valid", 32'(bus.result_valid), 32'd1);
        wait_idle("fixed");
        check("fixed_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Iteration limit, and max_iter of 0 read as 1.
        stub_mode = MODE_INC;
        push_exp(8'h10, 16'd4, 2'd0);
        run_sweep("limit4", 8'h10, 16'd1, 16'd4);
        push_exp(8'h20, 16'd1, 2'd0);
        run_sweep("limit0", 8'h20, 16'd1, 16'd0);

        // Sweep wrapping past all-ones.
        stub_mode = MODE_HOLD;
        push_exp(8'hFE, 16'd1, 2'd1);
        push_exp(8'hFF, 16'd1, 2'd1);
        push_exp(8'h00, 16'd1, 2'd1);
        run_sweep("wrap", 8'hFE, 16'd3, 16'd5);

        // Back-pressure: hold ready low for 10 RES cycles.
        push_exp(8'h40, 16'd1, 2'd1);
        push_exp(8'h41, 16'd1, 2'd1);
        bus.result_ready = 1'b0;
        d0 = done_cnt;
        start_sweep(8'h40, 16'd2, 16'd5);
        for (k = 0; k < 50; k++) begin
            if (bus.result_valid) break;
            tick();
        end
        check("bp_valid_reached", 32'(bus.result_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid_held", 32'(bus.result_valid), 32'd1);
            check("bp_init_held", 32'(bus.result_init), 32'h40);
            check("bp_steps_held", 32'(bus.result_steps), 32'd1);
            check("bp_no_strobes", 32'({bus.reset_nos, bus.start_s0, bus.start_s1}), 32'd0);
        end
        bus.result_ready = 1'b1;
        tick();
        check("bp_advance_load", 32'(bus.reset_nos), 32'd1);
        check("bp_advance_init", 32'(bus.init_state), 32'h41);
        wait_idle("bp");
        check("bp_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Alternating A5/5A.
        stub_mode = MODE_ALT;
`ifdef GNR_SWEEP_PERIOD2_EN
        push_exp(8'hA5, 16'd2, 2'd2);
        run_sweep("period2", 8'hA5, 16'd1, 16'd10);
`else
        push_exp(8'hA5, 16'd6, 2'd0);
        run_sweep("alt_limit", 8'hA5, 16'd1, 16'd6);
`endif

        // Empty sweep: done only, no record.
        run_sweep("empty", 8'h77, 16'd0, 16'd3);

        // Reset while in PH1.
        stub_mode = MODE_INC;
        d0 = done_cnt;
        start_sweep(8'h00, 16'd1, 16'd100);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.start_s1) break;
        end
        check("midrst_reached_ph1", 32'(bus.start_s1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // New sweep right after release.
        stub_mode = MODE_HOLD;
        push_exp(8'h3C, 16'd1, 2'd1);
        run_sweep("after_rst", 8'h3C, 16'd1, 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
